// File: rtl/cpu_pkg.sv
// Shared CPU definitions: one-hot execution classes, RV32I opcodes and the HALT word.
// Used by inst_decoder and by the control FSM.
package cpu_pkg;

  localparam int unsigned ExecW = 12;

  typedef logic [ExecW-1:0] exec_t;

  localparam exec_t ExecLw   = 12'h001;
  localparam exec_t ExecSlli = 12'h002;
  localparam exec_t ExecSw   = 12'h004;
  localparam exec_t ExecBeq  = 12'h008;
  localparam exec_t ExecAdd  = 12'h010;
  localparam exec_t ExecSub  = 12'h020;
  localparam exec_t ExecSll  = 12'h040;
  localparam exec_t ExecXor  = 12'h080;
  localparam exec_t ExecOr   = 12'h100;
  localparam exec_t ExecJal  = 12'h200;
  localparam exec_t ExecHalt = 12'h400;
  localparam exec_t ExecAnd  = 12'h800;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [31:0] HaltWord = 32'h0010_0073;

  localparam logic [6:0] Funct7Base = 7'b0000000;
  localparam logic [6:0] Funct7Alt  = 7'b0100000;

  // Everything the decoder captures on a load_inst cycle.
  typedef struct packed {
    exec_t       execution;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/inst_decoder_imm_gen.sv
// Combinational immediate generator; selects the immediate format from the
// already-decoded one-hot execution class.
module imm_gen
  import cpu_pkg::*;
(
  input  logic [31:0] inst_i,
  input  exec_t       execution_i,
  output logic [31:0] imm_o
);

  // Opcode bits are already folded into execution_i.
  logic unused_opcode;
  assign unused_opcode = ^inst_i[6:0];

  always_comb begin
    imm_o = '0;
    unique case (execution_i)
      ExecLw:   imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      ExecSlli: imm_o = {26'b0, inst_i[25:20]};
      ExecSw:   imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      ExecBeq:  imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                         inst_i[11:8], 1'b0};
      ExecJal:  imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                         inst_i[30:21], 1'b0};
      default:  imm_o = '0;
    endcase
  end

endmodule

// File: rtl/inst_decoder.sv
// Registered instruction decoder: captures the ROM word on load_inst, decodes it to a
// one-hot execution class plus operands, and tracks a sticky illegal flag and count.
module inst_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     inst_i,
  input  logic            load_inst_i,
  input  logic            dec_en_i,
  output logic [11:0]     execution_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [31:0]     alu_data2_o,
  output logic            illegal_o,
  output logic [CntW-1:0] inst_count_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  exec_t       exec_dec;
  logic        illegal_dec;
  logic [31:0] imm_dec;

  // Anything not matched exactly falls through to HALT so the CPU parks.
  always_comb begin
    exec_dec    = ExecHalt;
    illegal_dec = 1'b1;
    unique case (opcode)
      OpLoad: begin
        if (funct3 == 3'b010) begin
          exec_dec    = ExecLw;
          illegal_dec = 1'b0;
        end
      end
      OpImm: begin
        if (funct3 == 3'b001 && inst_i[31:26] == 6'b0) begin
          exec_dec    = ExecSlli;
          illegal_dec = 1'b0;
        end
      end
      OpStore: begin
        if (funct3 == 3'b010) begin
          exec_dec    = ExecSw;
          illegal_dec = 1'b0;
        end
      end
      OpBranch: begin
        if (funct3 == 3'b000) begin
          exec_dec    = ExecBeq;
          illegal_dec = 1'b0;
        end
      end
      OpReg: begin
        illegal_dec = 1'b0;
        unique case ({funct7, funct3})
          {Funct7Base, 3'b000}: exec_dec = ExecAdd;
          {Funct7Alt,  3'b000}: exec_dec = ExecSub;
          {Funct7Base, 3'b001}: exec_dec = ExecSll;
          {Funct7Base, 3'b100}: exec_dec = ExecXor;
          {Funct7Base, 3'b110}: exec_dec = ExecOr;
          {Funct7Base, 3'b111}: exec_dec = ExecAnd;
          default: begin
            exec_dec    = ExecHalt;
            illegal_dec = 1'b1;
          end
        endcase
      end
      OpJal: begin
        exec_dec    = ExecJal;
        illegal_dec = 1'b0;
      end
      OpSystem: begin
        if (inst_i == HaltWord) begin
          exec_dec    = ExecHalt;
          illegal_dec = 1'b0;
        end
      end
      default: begin
        exec_dec    = ExecHalt;
        illegal_dec = 1'b1;
      end
    endcase
  end

  imm_gen u_imm_gen (
    .inst_i      (inst_i),
    .execution_i (exec_dec),
    .imm_o       (imm_dec)
  );

  dec_t            dec_d, dec_q;
  logic            dec_en_q;
  logic            illegal_d, illegal_q;
  logic [CntW-1:0] count_d, count_q;
  logic            dec_en_rise;

  assign dec_en_rise = dec_en_i & ~dec_en_q;

  always_comb begin
    dec_d     = dec_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    if (load_inst_i) begin
      dec_d.execution = exec_dec;
      dec_d.rs1       = inst_i[19:15];
      dec_d.rs2       = inst_i[24:20];
      dec_d.rd        = inst_i[11:7];
      dec_d.imm       = imm_dec;
      dec_d.illegal   = illegal_dec;
    end
    // Uses the already-registered decode, i.e. the instruction control accepted.
    if (dec_en_rise) begin
      count_d   = count_q + CntW'(1);
      illegal_d = illegal_q | dec_q.illegal;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dec_q     <= '0;
      dec_en_q  <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      dec_q     <= dec_d;
      dec_en_q  <= dec_en_i;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign execution_o  = dec_q.execution;
  assign rs1_o        = dec_q.rs1;
  assign rs2_o        = dec_q.rs2;
  assign rd_o         = dec_q.rd;
  assign alu_data2_o  = dec_q.imm;
  assign illegal_o    = illegal_q;
  assign inst_count_o = count_q;

endmodule

// File: tb/tb_inst_decoder.sv
// Directed bench for inst_decoder; a second 4-bit-counter instance shares the stimulus
// so counter wrap can be exercised in a few cycles.
module tb_inst_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_inst;
  logic        dec_en;
  logic [31:0] inst;

  logic [11:0] execution, execution_s;
  logic [4:0]  rs1, rs2, rd, rs1_s, rs2_s, rd_s;
  logic [31:0] alu_data2, alu_data2_s;
  logic        illegal, illegal_s;
  logic [15:0] inst_count;
  logic [3:0]  inst_count_s;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  inst_decoder #(.CntW(16)) u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .inst_i       (inst),
    .load_inst_i  (load_inst),
    .dec_en_i     (dec_en),
    .execution_o  (execution),
    .rs1_o        (rs1),
    .rs2_o        (rs2),
    .rd_o         (rd),
    .alu_data2_o  (alu_data2),
    .illegal_o    (illegal),
    .inst_count_o (inst_count)
  );

  inst_decoder #(.CntW(4)) u_dut_small (
    .clk_i        (clk),
    .rst_i        (rst),
    .inst_i       (inst),
    .load_inst_i  (load_inst),
    .dec_en_i     (dec_en),
    .execution_o  (execution_s),
    .rs1_o        (rs1_s),
    .rs2_o        (rs2_s),
    .rd_o         (rd_s),
    .alu_data2_o  (alu_data2_s),
    .illegal_o    (illegal_s),
    .inst_count_o (inst_count_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_dec(input string tag, input logic [11:0] e_exec, input logic [4:0] e_rs1,
                           input logic [4:0] e_rs2, input logic [4:0] e_rd,
                           input logic [31:0] e_imm);
    check_eq({tag, ".exec"}, {20'b0, execution}, {20'b0, e_exec});
    check_eq({tag, ".rs1"},  {27'b0, rs1}, {27'b0, e_rs1});
    check_eq({tag, ".rs2"},  {27'b0, rs2}, {27'b0, e_rs2});
    check_eq({tag, ".rd"},   {27'b0, rd},  {27'b0, e_rd});
    check_eq({tag, ".imm"},  alu_data2, e_imm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two-cycle capture as control does it, then scramble inst to prove the hold.
  task automatic load_word(input logic [31:0] w);
    inst      = w;
    load_inst = 1'b1;
    step();
    step();
    load_inst = 1'b0;
    inst      = 32'hDEAD_BEEF;
  endtask

  task automatic pulse(input int n);
    dec_en = 1'b1;
    repeat (n) step();
    dec_en = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    load_inst = 1'b0;
    dec_en    = 1'b0;
    inst      = 32'h0;
    step();
    step();
    rst = 1'b0;

    check_dec("reset", 12'h000, 5'd0, 5'd0, 5'd0, 32'h0);
    check_eq("reset.illegal", {31'b0, illegal}, 32'd0);
    check_eq("reset.count", {16'b0, inst_count}, 32'd0);

    // LW x5,-4(x2): visible after the first capture edge already
    inst      = 32'hFFC1_2283;
    load_inst = 1'b1;
    step();
    check_eq("lw.first_edge", {20'b0, execution}, 32'h001);
    step();
    load_inst = 1'b0;
    inst      = 32'hDEAD_BEEF;
    check_dec("lw", 12'h001, 5'd2, 5'd28, 5'd5, 32'hFFFF_FFFC);
    check_eq("lw.illegal", {31'b0, illegal}, 32'd0);

    // SW x7,8(x1), then hold for four idle cycles
    load_word(32'h0070_A423);
    for (int i = 0; i < 4; i++) begin
      step();
      check_dec($sformatf("sw.hold%0d", i), 12'h004, 5'd1, 5'd7, 5'd8, 32'h0000_0008);
    end

    load_word(32'h0100_00EF);
    check_dec("jal", 12'h200, 5'd0, 5'd16, 5'd1, 32'h0000_0010);
    load_word(32'h0020_F1B3);
    check_dec("and", 12'h800, 5'd1, 5'd2, 5'd3, 32'h0);
    load_word(32'h0031_00B3);
    check_dec("add", 12'h010, 5'd2, 5'd3, 5'd1, 32'h0);
    load_word(32'h4031_00B3);
    check_dec("sub", 12'h020, 5'd2, 5'd3, 5'd1, 32'h0);
    load_word(32'h0051_1093);
    check_dec("slli", 12'h002, 5'd2, 5'd5, 5'd1, 32'h0000_0005);
    load_word(32'hFE20_8CE3);
    check_dec("beq", 12'h008, 5'd1, 5'd2, 5'd25, 32'hFFFF_FFF8);

    // HALT word is legal
    load_word(32'h0010_0073);
    pulse(1);
    check_dec("halt", 12'h400, 5'd0, 5'd1, 5'd0, 32'h0);
    check_eq("halt.illegal", {31'b0, illegal}, 32'd0);
    check_eq("halt.count", {16'b0, inst_count}, 32'd1);

    // Illegal word: flag only rises once dec_en accepts it, then sticks
    load_word(32'hFFFF_FFFF);
    check_dec("bad", 12'h400, 5'd31, 5'd31, 5'd31, 32'h0);
    check_eq("bad.pre_accept", {31'b0, illegal}, 32'd0);
    pulse(1);
    check_eq("bad.illegal", {31'b0, illegal}, 32'd1);
    check_eq("bad.count", {16'b0, inst_count}, 32'd2);
    load_word(32'h0031_00B3);
    pulse(1);
    check_eq("sticky.exec", {20'b0, execution}, 32'h010);
    check_eq("sticky.illegal", {31'b0, illegal}, 32'd1);
    check_eq("sticky.count", {16'b0, inst_count}, 32'd3);

    do_reset();
    check_eq("rst2.illegal", {31'b0, illegal}, 32'd0);
    check_eq("rst2.count", {16'b0, inst_count}, 32'd0);

    // Held dec_en counts once
    pulse(1);
    pulse(2);
    check_eq("cnt.after2", {16'b0, inst_count}, 32'd2);
    pulse(1);
    check_eq("cnt.after3", {16'b0, inst_count}, 32'd3);

    // Wrap of the 4-bit counter instance
    do_reset();
    repeat (15) pulse(1);
    check_eq("wrap.small15", {28'b0, inst_count_s}, 32'd15);
    check_eq("wrap.big15", {16'b0, inst_count}, 32'd15);
    pulse(1);
    check_eq("wrap.small0", {28'b0, inst_count_s}, 32'd0);
    check_eq("wrap.big16", {16'b0, inst_count}, 32'd16);

    // Reset wins over load_inst and dec_en in the same cycle
    load_word(32'hFFFF_FFFF);
    pulse(1);
    check_eq("mid.pre_illegal", {31'b0, illegal}, 32'd1);
    inst      = 32'hFFC1_2283;
    load_inst = 1'b1;
    dec_en    = 1'b1;
    rst       = 1'b1;
    step();
    rst       = 1'b0;
    load_inst = 1'b0;
    dec_en    = 1'b0;
    check_dec("mid_rst", 12'h000, 5'd0, 5'd0, 5'd0, 32'h0);
    check_eq("mid_rst.illegal", {31'b0, illegal}, 32'd0);
    check_eq("mid_rst.count", {16'b0, inst_count}, 32'd0);
    step();
    load_word(32'h0070_A423);
    check_dec("resume", 12'h004, 5'd1, 5'd7, 5'd8, 32'h0000_0008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
